alu_slot_sched: RTL and testbench

ALU_SLOT_SCHED -- requirements
Module: alu_slot_sched

---
 rtl/alu_sched_pkg.sv | 18 +
 rtl/slot_timer.sv | 67 ++++++
 rtl/alu_slot_sched.sv | 117 +++++++++++
 tb/tb_alu_slot_sched.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared defaults and types for the time-slotted shared-ALU scheduler.
package alu_sched_pkg;

    localparam int DEF_WIDTH    = 1;
    localparam int DEF_SLOT_LEN = 2;
    localparam int DEF_ALU_LAT  = 1;

    // ISSUE is the single cycle at the start of a slot (slot_cnt == 0).
    // DRAIN covers the rest of the slot (slot_cnt 1..SLOT_LEN-1).
    typedef enum logic {
        ISSUE = 1'b0,
        DRAIN = 1'b1
    } slot_state_t;

    // Index of a requester: 0 or 1.
    typedef logic owner_t;

endpackage

// File: rtl/slot_timer.sv
// Slot timer: counts cycles within a slot, tracks ISSUE/DRAIN and
// alternates the slot owner 0,1,0,1,... at every slot boundary.
module slot_timer
    import alu_sched_pkg::*;
#(
    parameter int SLOT_LEN = DEF_SLOT_LEN
) (
    input  logic        clk,
    input  logic        rst,
    output slot_state_t o_state,
    output owner_t      o_owner
);

    localparam int             CW       = $clog2(SLOT_LEN);
    localparam logic [CW-1:0]  LAST_CNT = CW'(SLOT_LEN - 1);

    slot_state_t   r_state;
    slot_state_t   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    owner_t        r_owner;
    owner_t        w_owner_nxt;

    // State register: synchronous reset to ISSUE, count 0, owner 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            r_state <= ISSUE;
            r_cnt   <= '0;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Next-state logic: ISSUE always moves to DRAIN; DRAIN wraps to ISSUE
    // on the last cycle of the slot and hands the slot to the other owner.
    always_comb begin
        // NOTE: every output of this block gets a default first so no
        // path through the case can leave a latch behind.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        case (r_state)
            ISSUE: begin
                w_state_nxt = DRAIN;
                w_cnt_nxt   = r_cnt + CW'(1);
            end
            DRAIN: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_nxt = ISSUE;
                    w_cnt_nxt   = '0;
                    w_owner_nxt = ~r_owner;
                end else begin
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
            end
        endcase
    end

    assign o_state = r_state;
    assign o_owner = r_owner;

endmodule

// File: rtl/alu_slot_sched.sv
// Time-slotted arbiter for two requesters sharing one pipelined ALU.
// Each requester may issue only in the ISSUE cycle of its own slot; the
// ALU result is captured and returned to the requester recorded at issue.
module alu_slot_sched
    import alu_sched_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SLOT_LEN = DEF_SLOT_LEN,
    parameter int ALU_LAT  = DEF_ALU_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic             rsp_valid0,
    output logic [WIDTH-1:0] rsp_data0,
    output logic             rsp_valid1,
    output logic [WIDTH-1:0] rsp_data1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_o,
    output logic             slot_owner
);

    slot_state_t        w_state;
    owner_t             w_owner;
    logic               w_issue;
    logic               w_done;
    owner_t             w_done_own;

    logic [ALU_LAT-1:0] r_pipe_vld;
    logic [ALU_LAT-1:0] r_pipe_own;
    logic               r_rsp_valid0;
    logic [WIDTH-1:0]   r_rsp_data0;
    logic               r_rsp_valid1;
    logic [WIDTH-1:0]   r_rsp_data1;

    slot_timer #(
        .SLOT_LEN (SLOT_LEN)
    ) u_slot_timer (
        .clk     (clk),
        .rst     (rst),
        .o_state (w_state),
        .o_owner (w_owner)
    );

    // Grants are only possible in ISSUE, only to the slot owner, and never
    // while reset is held.
    assign w_issue = (w_state == ISSUE) && !rst;
    assign ack0    = w_issue && (w_owner == 1'b0) && req0;
    assign ack1    = w_issue && (w_owner == 1'b1) && req1;

    // Operand mux: drive the granted requester's operands, zero otherwise.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        if (ack0) begin
            alu_a = a0;
            alu_b = b0;
        end else if (ack1) begin
            alu_a = a1;
            alu_b = b1;
        end
    end

    // Issue tracking: a valid bit and the issuing owner ride alongside the
    // ALU so a result crossing a slot boundary still finds its requester.
    always_ff @(posedge clk) begin
        // NOTE: the tracking bits are reset so an in-flight operation is
        // forgotten by reset and never produces a late response.
        if (rst) begin
            r_pipe_vld <= '0;
            r_pipe_own <= '0;
        end else begin
            r_pipe_vld[0] <= ack0 || ack1;
            r_pipe_own[0] <= ack1;
            for (int i = 1; i < ALU_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_own[i] <= r_pipe_own[i-1];
            end
        end
    end

    assign w_done     = r_pipe_vld[ALU_LAT-1];
    assign w_done_own = r_pipe_own[ALU_LAT-1];

    // Response capture: register alu_o into the issuing requester's port
    // for a single cycle; the idle port's data is held at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid0 <= 1'b0;
            r_rsp_data0  <= '0;
            r_rsp_valid1 <= 1'b0;
            r_rsp_data1  <= '0;
        end else begin
            r_rsp_valid0 <= w_done && (w_done_own == 1'b0);
            r_rsp_data0  <= (w_done && (w_done_own == 1'b0)) ? alu_o : '0;
            r_rsp_valid1 <= w_done && (w_done_own == 1'b1);
            r_rsp_data1  <= (w_done && (w_done_own == 1'b1)) ? alu_o : '0;
        end
    end

    // The response registers only clear at the reset edge, so mask them
    // while reset is held to keep the outputs quiet for the whole reset.
    assign rsp_valid0 = r_rsp_valid0 && !rst;
    assign rsp_data0  = rst ? '0 : r_rsp_data0;
    assign rsp_valid1 = r_rsp_valid1 && !rst;
    assign rsp_data1  = rst ? '0 : r_rsp_data1;
    assign slot_owner = w_owner;

endmodule

// File: tb/tb_alu_slot_sched.sv
// Self-checking bench for alu_slot_sched with a registered AND as the
// attached ALU. A cycle-count model predicts grants; predicted responses
// go into per-port queues and are matched when they fall due. A second
// instance shares requester-0 stimulus but sees independent requester-1
// stimulus, and its port 0 is held to the same predictions.
module tb_alu_slot_sched;

    localparam int WIDTH    = 1;
    localparam int SLOT_LEN = 2;
    localparam int ALU_LAT  = 1;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] d;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0, req1 = 1'b0, req1_b = 1'b0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, a1_b = '0, b1_b = '0;

    logic             ack0, ack1, rsp_valid0, rsp_valid1, slot_owner;
    logic [WIDTH-1:0] rsp_data0, rsp_data1, alu_a, alu_b;
    logic [WIDTH-1:0] r_alu_o = '0;

    logic             ack0_b, ack1_b, rsp_valid0_b, rsp_valid1_b, slot_owner_b;
    logic [WIDTH-1:0] rsp_data0_b, rsp_data1_b, alu_a_b, alu_b_b;
    logic [WIDTH-1:0] r_alu_o_b = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q0b[$];

    always #5 clk = ~clk;

    alu_slot_sched #(.WIDTH(WIDTH), .SLOT_LEN(SLOT_LEN), .ALU_LAT(ALU_LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1),
        .rsp_valid0(rsp_valid0), .rsp_data0(rsp_data0),
        .rsp_valid1(rsp_valid1), .rsp_data1(rsp_data1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_o(r_alu_o),
        .slot_owner(slot_owner)
    );

    alu_slot_sched #(.WIDTH(WIDTH), .SLOT_LEN(SLOT_LEN), .ALU_LAT(ALU_LAT)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1_b), .a1(a1_b), .b1(b1_b),
        .ack0(ack0_b), .ack1(ack1_b),
        .rsp_valid0(rsp_valid0_b), .rsp_data0(rsp_data0_b),
        .rsp_valid1(rsp_valid1_b), .rsp_data1(rsp_data1_b),
        .alu_a(alu_a_b), .alu_b(alu_b_b), .alu_o(r_alu_o_b),
        .slot_owner(slot_owner_b)
    );

    // Team ALU stand-in: bitwise AND with one register stage.
    always @(posedge clk) begin
        r_alu_o   <= alu_a & alu_b;
        r_alu_o_b <= alu_a_b & alu_b_b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic             exp_issue, exp_owner, exp_ack0, exp_ack1;
        logic [WIDTH-1:0] exp_a, exp_b;
        exp_t             e;
        if (rst) begin
            check("rst_ack0", ack0, 0);
            check("rst_ack1", ack1, 0);
            check("rst_rsp_valid0", rsp_valid0, 0);
            check("rst_rsp_valid1", rsp_valid1, 0);
            check("rst_rsp_data0", rsp_data0, 0);
            check("rst_rsp_data1", rsp_data1, 0);
            check("rst_alu_a", alu_a, 0);
            check("rst_alu_b", alu_b, 0);
            check("rst_rsp_valid0_b", rsp_valid0_b, 0);
            q0.delete();
            q1.delete();
            q0b.delete();
            cyc = 0;
        end else begin
            exp_issue = (cyc % SLOT_LEN) == 0;
            exp_owner = ((cyc / SLOT_LEN) % 2) == 1;
            exp_ack0  = exp_issue && !exp_owner && req0;
            exp_ack1  = exp_issue && exp_owner && req1;
            exp_a     = exp_ack0 ? a0 : (exp_ack1 ? a1 : '0);
            exp_b     = exp_ack0 ? b0 : (exp_ack1 ? b1 : '0);
            check("slot_owner", slot_owner, exp_owner);
            check("ack0", ack0, exp_ack0);
            check("ack1", ack1, exp_ack1);
            check("alu_a", alu_a, exp_a);
            check("alu_b", alu_b, exp_b);
            check("ack0_b", ack0_b, exp_ack0);
            e.cyc = cyc + ALU_LAT + 1;
            if (exp_ack0) begin
                e.d = a0 & b0;
                q0.push_back(e);
                q0b.push_back(e);
            end
            if (exp_ack1) begin
                e.d = a1 & b1;
                q1.push_back(e);
            end
            if (q0.size() > 0 && q0[0].cyc == cyc) begin
                check("rsp_valid0", rsp_valid0, 1);
                check("rsp_data0", rsp_data0, q0[0].d);
                void'(q0.pop_front());
            end else begin
                check("rsp_idle0", rsp_valid0, 0);
                check("rsp_zero0", rsp_data0, 0);
            end
            if (q1.size() > 0 && q1[0].cyc == cyc) begin
                check("rsp_valid1", rsp_valid1, 1);
                check("rsp_data1", rsp_data1, q1[0].d);
                void'(q1.pop_front());
            end else begin
                check("rsp_idle1", rsp_valid1, 0);
                check("rsp_zero1", rsp_data1, 0);
            end
            if (q0b.size() > 0 && q0b[0].cyc == cyc) begin
                check("rsp_valid0_b", rsp_valid0_b, 1);
                check("rsp_data0_b", rsp_data0_b, q0b[0].d);
                void'(q0b.pop_front());
            end else begin
                check("rsp_idle0_b", rsp_valid0_b, 0);
                check("rsp_zero0_b", rsp_data0_b, 0);
            end
            cyc++;
        end
    end

    task automatic start_scenario();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        step(2);

        // V1: requester 0 only, a0=b0=1.
        req0 = 1'b1; a0 = 1'b1; b0 = 1'b1;
        req1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        start_scenario();
        step(8);

        // V2: requester 1 only, a1=1, b1=0.
        req0 = 1'b0; a0 = 1'b0; b0 = 1'b0;
        req1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        start_scenario();
        step(8);

        // V3: both requesting continuously with distinguishable results.
        req0 = 1'b1; a0 = 1'b1; b0 = 1'b1;
        req1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        start_scenario();
        step(14);

        // V4: requester 0 only; requester 1 slots are wasted.
        req1 = 1'b0;
        start_scenario();
        step(12);

        // V5: reset right after an ack drops the in-flight response.
        req0 = 1'b1; a0 = 1'b1; b0 = 1'b1;
        start_scenario();
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(6);

        // V6: shared requester-0 stimulus, independent requester-1 stimulus.
        start_scenario();
        for (int i = 0; i < 40; i++) begin
            req0 = 1'($urandom_range(0, 1));
            a0   = WIDTH'($urandom);
            b0   = WIDTH'($urandom);
            req1 = 1'($urandom_range(0, 1));
            a1   = WIDTH'($urandom);
            b1   = WIDTH'($urandom);
            req1_b = 1'($urandom_range(0, 1));
            a1_b   = WIDTH'($urandom);
            b1_b   = WIDTH'($urandom);
            step(1);
        end
        req0 = 1'b0; req1 = 1'b0; req1_b = 1'b0;
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
